// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, digit type and the hex-to-segment table for the
// 4-digit common-anode scanner.
//   DIGIT_W    width of one digit code {dot, hex nibble}
//   NUM_DIGITS number of multiplexed digits
//   SEG_BLANK  all cathodes off (active-low)
//   ANODE_OFF  all anodes off (active-low)
//   hex_to_seg nibble -> 7-bit active-low pattern, bit0 = a .. bit6 = g
package seg7_pkg;

  localparam int DIGIT_W    = 5;
  localparam int NUM_DIGITS = 4;

  localparam logic [7:0]            SEG_BLANK = 8'hFF;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = '1;

  typedef struct packed {
    logic       dot;
    logic [3:0] hex;
  } digit_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] segs;
    segs = 7'h7F;
    case (nibble)
      4'h0: segs = 7'h40;
      4'h1: segs = 7'h79;
      4'h2: segs = 7'h24;
      4'h3: segs = 7'h30;
      4'h4: segs = 7'h19;
      4'h5: segs = 7'h12;
      4'h6: segs = 7'h02;
      4'h7: segs = 7'h78;
      4'h8: segs = 7'h00;
      4'h9: segs = 7'h10;
      4'hA: segs = 7'h08;
      4'hB: segs = 7'h03;
      4'hC: segs = 7'h46;
      4'hD: segs = 7'h21;
      4'hE: segs = 7'h06;
      4'hF: segs = 7'h0E;
      default: segs = 7'h7F;
    endcase
    return segs;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: bundle between the display register bank / board pins
// and the scanner.
//   in_a..in_d  digit codes {dot, hex}, in_a rightmost
//   digit_en    per-digit enable (live)
//   bright      PWM brightness, 7 = full, 0 = 1/8 duty (live)
//   seg_select  anode select, active-low
//   dec_out     cathodes, active-low, [7] = DP
//   frame_start one-cycle pulse after each new snapshot
// master: the side that supplies digits and watches the pins.
// slave : the scanner itself.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic [DIGIT_W-1:0]    in_a;
  logic [DIGIT_W-1:0]    in_b;
  logic [DIGIT_W-1:0]    in_c;
  logic [DIGIT_W-1:0]    in_d;
  logic [NUM_DIGITS-1:0] digit_en;
  logic [2:0]            bright;
  logic [NUM_DIGITS-1:0] seg_select;
  logic [7:0]            dec_out;
  logic                  frame_start;

  modport master (
    output in_a, in_b, in_c, in_d, digit_en, bright,
    input  seg_select, dec_out, frame_start
  );

  modport slave (
    input  in_a, in_b, in_c, in_d, digit_en, bright,
    output seg_select, dec_out, frame_start
  );

endinterface

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: combinational {dot, hex} -> 8-bit active-low cathode
// pattern.
//   i_digit  {dot, hex nibble}, dot = 1 means lit
//   o_dec    [6:0] = a..g, [7] = DP, all active-low
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [7:0]         o_dec
);

  digit_t w_digit;

  assign w_digit = digit_t'(i_digit);
  assign o_dec   = {~w_digit.dot, hex_to_seg(w_digit.hex)};

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed scanner for a 4-digit common-anode
// 7-segment display. Rotates through the digits one slot of REFRESH_DIV
// cycles at a time, blanks the first BLANK_CYCLES of every slot, applies
// brightness PWM and decodes the snapshotted digit onto the cathodes.
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   bus      seg7_scan_driver_if.slave (digits, enables, brightness, pins)
// Parameters: REFRESH_DIV >= 2, 1 <= BLANK_CYCLES < REFRESH_DIV.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic               i_clk,
  input logic               i_rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0]                   r_cnt;
  logic [IDX_W-1:0]                   r_idx;
  logic [2:0]                         r_pwm;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] r_snap;
  logic                               r_frame_start;
  logic [NUM_DIGITS-1:0]              r_seg_select;
  logic [7:0]                         r_dec_out;

  logic                  w_slot_end;
  logic                  w_frame_tick;
  logic                  w_lit;
  logic [DIGIT_W-1:0]    w_cur_digit;
  logic [7:0]            w_dec;
  logic [NUM_DIGITS-1:0] w_anode;

  assign w_slot_end   = (r_cnt == CNT_LAST);
  assign w_frame_tick = (r_cnt == '0) && (r_idx == '0);

  // cnt >= BLANK_CYCLES also guarantees the snapshot cycle (cnt == 0) is
  // never lit, so a new snapshot can never mix into a visible digit.
  assign w_lit = (r_cnt >= CNT_BLANK) && bus.digit_en[r_idx] && (r_pwm <= bus.bright);

  assign w_cur_digit = r_snap[r_idx];
  assign w_anode     = ~(NUM_DIGITS'(1) << r_idx);

  seg7_hex_decoder u_dec (
    .i_digit (w_cur_digit),
    .o_dec   (w_dec)
  );

  // Slot counter, digit index and free-running PWM phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_pwm <= '0;
    end else begin
      r_pwm <= r_pwm + 3'd1;
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Digits are frozen once per frame so a bus write cannot tear a frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_snap        <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_tick;
      if (w_frame_tick) begin
        r_snap <= {bus.in_d, bus.in_c, bus.in_b, bus.in_a};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seg_select <= ANODE_OFF;
      r_dec_out    <= SEG_BLANK;
    end else if (w_lit) begin
      r_seg_select <= w_anode;
      r_dec_out    <= w_dec;
    end else begin
      r_seg_select <= ANODE_OFF;
      r_dec_out    <= SEG_BLANK;
    end
  end

  assign bus.seg_select  = r_seg_select;
  assign bus.dec_out     = r_dec_out;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_driver_if if1 ();
  seg7_scan_driver_if if2 ();

  seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if1)
  );

  seg7_scan_driver #(.REFRESH_DIV(64), .BLANK_CYCLES(2)) dut_pwm (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if2)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic mon_en = 1'b0;

  logic [3:0] en_m;
  logic [7:0] exp_d [4];

  // Hand-written decode table, dot off.
  logic [7:0] dtab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Cycle c after reset release shows what was evaluated in cycle c-1.
  task automatic run(input int n);
    int e, pos, slot;
    logic lit;
    logic [3:0] es;
    logic [7:0] ed;
    repeat (n) begin
      @(negedge clk);
      cyc++;
      e    = cyc - 1;
      pos  = e % 8;
      slot = (e / 8) % 4;
      lit  = (pos >= 2) && en_m[slot];
      es   = 4'hF;
      ed   = 8'hFF;
      if (lit) begin
        es = ~(4'b0001 << slot);
        ed = exp_d[slot];
      end
      chk("seg_select", 32'(if1.seg_select), 32'(es));
      chk("dec_out", 32'(if1.dec_out), 32'(ed));
      chk("frame_start", 32'(if1.frame_start), 32'((e % 32) == 0));
    end
  endtask

  // Structural pin checks: never two anodes low, >= 2 blank cycles between digits.
  logic [3:0] last_lit = 4'hF;
  int blank_run = 0;
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      last_lit  = 4'hF;
      blank_run = 0;
    end else begin
      chk("one_low", 32'($countones(~if1.seg_select) <= 1), 32'd1);
      if (if1.seg_select == 4'hF) begin
        blank_run++;
      end else begin
        if (last_lit != 4'hF && if1.seg_select != last_lit)
          chk("blank_gap", 32'(blank_run >= 2), 32'd1);
        last_lit  = if1.seg_select;
        blank_run = 0;
      end
    end
  end

  initial begin
    int n;
    logic [3:0] v4;

    if1.in_a = 5'h03; if1.in_b = 5'h11; if1.in_c = 5'h0A; if1.in_d = 5'h1F;
    en_m = 4'hF; if1.digit_en = en_m; if1.bright = 3'd7;
    exp_d[0] = 8'hB0; exp_d[1] = 8'h79; exp_d[2] = 8'h88; exp_d[3] = 8'h0E;

    if2.in_a = 5'h08; if2.in_b = 5'h08; if2.in_c = 5'h08; if2.in_d = 5'h08;
    if2.digit_en = 4'hF; if2.bright = 3'd7;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_seg_select", 32'(if1.seg_select), 32'hF);
    chk("rst_dec_out", 32'(if1.dec_out), 32'hFF);
    chk("rst_frame_start", 32'(if1.frame_start), 32'h0);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    cyc    = 0;

    // Basic scan of first frame, into the second.
    run(50);
    // Input change mid-frame only shows after the next snapshot.
    if1.in_a = 5'h05; exp_d[0] = 8'h92;
    run(18);
    // Changing during the displayed slot must not tear it.
    if1.in_a = 5'h08;
    run(12);
    exp_d[0] = 8'h80;
    run(48);

    // Disabled digits still consume their slot.
    en_m = 4'b1010; if1.digit_en = en_m;
    run(32);
    en_m = 4'hF; if1.digit_en = en_m;
    run(16);

    // Decode sweep on digit 0, dot on for even values.
    for (int v = 0; v < 16; v++) begin
      v4 = 4'(v);
      if1.in_a = {~v4[0], v4};
      exp_d[0] = v4[0] ? dtab[v] : (dtab[v] & 8'h7F);
      run(32);
    end

    // Asynchronous reset in the middle of slot 2's lit window.
    run(5);
    rst_n = 1'b0;
    #1;
    chk("arst_seg_select", 32'(if1.seg_select), 32'hF);
    chk("arst_dec_out", 32'(if1.dec_out), 32'hFF);
    chk("arst_frame_start", 32'(if1.frame_start), 32'h0);
    if1.in_a = 5'h12; if1.in_b = 5'h07; if1.in_c = 5'h1C; if1.in_d = 5'h0D;
    exp_d[0] = 8'h24; exp_d[1] = 8'hF8; exp_d[2] = 8'h46; exp_d[3] = 8'hA1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    run(40);

    // PWM duty on the REFRESH_DIV=64 instance, counted over one full frame.
    if2.bright = 3'd0;
    repeat (2) @(negedge clk);
    n = 0;
    repeat (256) begin @(negedge clk); if (if2.seg_select != 4'hF) n++; end
    chk("pwm_bright0", 32'(n), 32'd28);

    if2.bright = 3'd3;
    repeat (2) @(negedge clk);
    n = 0;
    repeat (256) begin @(negedge clk); if (if2.seg_select != 4'hF) n++; end
    chk("pwm_bright3", 32'(n), 32'd120);

    if2.bright = 3'd7;
    repeat (2) @(negedge clk);
    n = 0;
    repeat (256) begin @(negedge clk); if (if2.seg_select != 4'hF) n++; end
    chk("pwm_bright7", 32'(n), 32'd248);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed scanner for the 4-digit, common-anode 7-segment display. It sits directly downstream of the bus-mapped display register bank, which supplies four 5-bit digit codes ({dot, hex nibble}). The block owns digit rotation, per-digit dead-time, brightness PWM and hex-to-segment decode, and drives SEG_SELECT/DEC_OUT to the board pins. Digit values are snapshotted once per frame, so a bus write can never tear a frame.

Parameters:
REFRESH_DIV, 100000, CLK cycles per digit slot (100 MHz -> 1 kHz slot rate, 250 Hz frame rate); must be >= 2
BLANK_CYCLES, 1000, cycles blanked at the start of each slot (anti-ghosting); must satisfy 1 <= BLANK_CYCLES < REFRESH_DIV

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-low reset
IN_A  input  5  digit 0 (rightmost): [4] = decimal point (1 = lit), [3:0] = hex value
IN_B  input  5  digit 1, same format
IN_C  input  5  digit 2, same format
IN_D  input  5  digit 3 (leftmost), same format
DIGIT_EN  input  4  per-digit enable; bit i gates digit i
BRIGHT  input  3  brightness; 7 = full, 0 = 1/8 duty
SEG_SELECT  output  4  anode select, active-low; bit i low = digit i lit
DEC_OUT  output  8  cathodes, active-low; [0]=a .. [6]=g, [7]=DP
FRAME_START  output  1  one-cycle pulse, asserted the cycle after a new snapshot is taken

Behaviour:
- Reset (RESET low, asynchronous):
  - SEG_SELECT=4'hF, DEC_OUT=8'hFF, FRAME_START=0.
  - Slot counter cnt=0, digit index idx=0, PWM counter pwm=0.
  - All snapshot registers = 5'h00.
- cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, idx increments mod 4 (0,1,2,3,0...).
  - pwm is a free-running 3-bit counter, incrementing every cycle and wrapping 7->0.
- Frame snapshot:
  - Taken on the clock edge ending any cycle with cnt==0 && idx==0, including the first cycle after reset release.
  - IN_A..IN_D are captured into the snapshot registers on that edge.
  - FRAME_START is high for exactly the following cycle.
  - Input changes at any other time have no effect until the next frame.
- Lit condition, evaluated each cycle: lit = (cnt >= BLANK_CYCLES) && DIGIT_EN[idx] && (pwm <= BRIGHT).
  - BRIGHT and DIGIT_EN are used live; they are not snapshotted.
- Outputs are registered with 1-cycle latency from the cycle in which lit/idx/cnt are evaluated.
  - If lit: SEG_SELECT = ~(4'b0001 << idx), DEC_OUT = {~dot, ~segs(hex)} of snapshot[idx].
  - Else: SEG_SELECT=4'hF, DEC_OUT=8'hFF.
- Decode (DEC_OUT with dot off):
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
  - Dot on clears bit 7 (e.g. 0 with dot -> 40).
- At most one SEG_SELECT bit is ever low.
  - SEG_SELECT is all-ones for at least BLANK_CYCLES cycles between any two different digits.
- Because BLANK_CYCLES >= 1, the first output cycle of each frame is always blank. The snapshot update therefore never shows mixed data.
- Disabled digit: its slot is still consumed (fixed scan timing) and the outputs stay blank for the whole slot.
- Reset asserted mid-slot: outputs go blank immediately (asynchronously). After release, scanning restarts at idx=0 with a fresh snapshot.

Decomposition:
- Shared package seg7_pkg:
  - DIGIT_W=5 and NUM_DIGITS=4 constants.
  - SEG_BLANK=8'hFF.
  - Function hex_to_seg(nibble) -> 7-bit active-low pattern.
- One sub-module, seg7_hex_decoder: purely combinational, {dot, hex} -> 8-bit active-low DEC_OUT pattern.
  - Instantiated once on the muxed snapshot digit.
  - Counters, snapshot and output registers live in seg7_scan_driver.

Test Plan:
(All with REFRESH_DIV=8, BLANK_CYCLES=2, unless stated.)
1. Reset then release; IN_A=5'h03, IN_B=5'h11, IN_C=5'h0A, IN_D=5'h1F, DIGIT_EN=F, BRIGHT=7 -> FRAME_START pulses in cycle 1. Expected per slot:
   - Slot 0: blank 2 cycles, then SEG_SELECT=E, DEC_OUT=B0 for 6 cycles.
   - Slot 1: SEG_SELECT=D, DEC_OUT=79.
   - Slot 2: SEG_SELECT=B, DEC_OUT=88.
   - Slot 3: SEG_SELECT=7, DEC_OUT=0E.
   - FRAME_START repeats every 32 cycles.
2. Change IN_A to 5'h05 during slot 2 -> digit 0 keeps showing B0 until the next FRAME_START, then shows 92.
3. DIGIT_EN=4'b1010 -> slots 0 and 2 are fully blank (SEG_SELECT=F, DEC_OUT=FF); slots 1 and 3 display normally; frame period stays 32 cycles.
4. BRIGHT=0, REFRESH_DIV=64 -> within the lit window a digit is driven only when pwm==0 (1 cycle in 8), otherwise blank; BRIGHT=3 -> 4 of every 8 cycles lit.
5. Drop RESET low mid-slot 2 -> same-cycle SEG_SELECT=F, DEC_OUT=FF, FRAME_START=0; after release, idx=0 and a new snapshot is taken in cycle 1.
6. Sweep all 16 hex values plus dot on digit 0 -> DEC_OUT matches the decode table exactly; SEG_SELECT is never two-low and never switches digit without ≥2 blank cycles.
